// File: rtl/fetch_pkg.sv
// Shared opcode constants, ROM depth default and the prefetch entry type.
// Pure definitions, no logic, no timing, no flow control.
package fetch_pkg;
    localparam logic [1:0] OPC_ALU       = 2'b11;
    localparam logic [2:0] OPR_LDI       = 3'b111;
    localparam int         ROM_DEPTH_DEF = 128;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] data;
    } entry_t;

    function automatic logic is_ldi_op(input logic [7:0] b);
        return (b[7:6] == OPC_ALU) && (b[5:3] == OPR_LDI);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch ring buffer with single push, pop-1/pop-2 and flush; head/next read combinationally, 0-cycle.
// Backpressure: caller must never push when full or pop more than count; flush and rst empty it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       push_entry,
    input  logic                         pop1,
    input  logic                         pop2,
    output entry_t                       head,
    output entry_t                       next,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [1:0]      pop_n;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = (PW+1)'(p) + (PW+1)'(n);
        if (s >= (PW+1)'(DEPTH))
            s = s - (PW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign pop_n = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
    assign head  = mem[rd_ptr];
    assign next  = mem[ptr_add(rd_ptr, 2'd1)];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_add(wr_ptr, 2'd1);
            rd_ptr <= ptr_add(rd_ptr, pop_n);
            count  <= CW'({1'b0, count} + (CW+1)'(push) - (CW+1)'(pop_n));
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetcher: ROM -> FIFO -> instruction register, LDI pairs delivered as one transfer, 0-cycle from FIFO head.
// Backpressure: instr_ready low fills the FIFO then stops fetch; br flushes. INSTR_FETCH_PERF_EN adds perf counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ROM_DEPTH = ROM_DEPTH_DEF,
    parameter int BUF_DEPTH = 4
)(
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_addr,
    output logic        rom_re_bar,
    input  logic [7:0]  rom_data,
    input  logic        br,
    input  logic [7:0]  br_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr,
    output logic [7:0]  imm,
    output logic        is_ldi,
    output logic [7:0]  instr_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt,
    output logic [15:0] flush_cnt
`endif
);
    localparam int         CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [7:0] FPC_LAST = 8'(ROM_DEPTH - 1);

    logic [7:0]    fpc;
    entry_t        head;
    entry_t        next;
    logic [CW-1:0] count;
    logic          head_ldi;
    logic          valid_raw;
    logic          transfer;
    logic          pop1;
    logic          pop2;
    logic [1:0]    pop_n;
    logic [CW:0]   used_after_pop;
    logic          fetch;

    assign head_ldi  = is_ldi_op(head.data);
    assign valid_raw = head_ldi ? (count >= CW'(2)) : (count != '0);

    assign instr_valid = valid_raw && !rst;
    assign transfer    = instr_valid && instr_ready;
    assign pop1        = transfer && !head_ldi;
    assign pop2        = transfer && head_ldi;
    assign pop_n       = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);

    // Space freed by this cycle's pop counts towards the fetch decision.
    assign used_after_pop = {1'b0, count} - (CW+1)'(pop_n);
    assign fetch          = !br && !rst && (used_after_pop < (CW+1)'(BUF_DEPTH));

    assign rom_addr   = fpc;
    assign rom_re_bar = !fetch;

    assign instr    = instr_valid ? head.data : 8'h00;
    assign instr_pc = instr_valid ? head.pc   : 8'h00;
    assign is_ldi   = instr_valid && head_ldi;
    assign imm      = is_ldi ? next.data : 8'h00;

    always_ff @(posedge clk) begin
        if (rst)
            fpc <= '0;
        else if (br)
            fpc <= 8'(int'(br_target) % ROM_DEPTH);
        else if (fetch)
            fpc <= (fpc == FPC_LAST) ? 8'h00 : fpc + 8'd1;
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (br),
        .push       (fetch),
        .push_entry ({fpc, rom_data}),
        .pop1       (pop1),
        .pop2       (pop2),
        .head       (head),
        .next       (next),
        .count      (count)
    );

`ifdef INSTR_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fetch && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (br && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected transfers, a negedge monitor pops and compares.
module tb_instr_fetch;
    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ins;
        logic       ldi;
        logic [7:0] imm;
    } xfer_t;

    logic       clk;
    logic       rst;
    logic [7:0] rom_addr;
    logic       rom_re_bar;
    logic [7:0] rom_data;
    logic       br;
    logic [7:0] br_target;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] imm;
    logic       is_ldi;
    logic [7:0] instr_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    logic [7:0] rom [128];
    xfer_t      exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_xfer   = 0;

    instr_fetch #(
        .ROM_DEPTH (128),
        .BUF_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_re_bar  (rom_re_bar),
        .rom_data    (rom_data),
        .br          (br),
        .br_target   (br_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .is_ldi      (is_ldi),
        .instr_pc    (instr_pc)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[6:0]];

    initial begin
        for (int i = 0; i < 128; i++)
            rom[i] = 8'(i);
        rom[0] = 8'h01;
        rom[1] = 8'h0A;
        rom[2] = 8'h13;
        rom[3] = 8'h1C;
        rom[5] = 8'hF9;
        rom[6] = 8'h7F;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void ex(input logic [7:0] pc, input logic [7:0] ins,
                               input logic l, input logic [7:0] im);
        exp_q.push_back({pc, ins, l, im});
    endfunction

    function automatic void ex_plain(input int from, input int to);
        for (int a = from; a <= to; a++)
            exp_q.push_back({8'(a), 8'(a), 1'b0, 8'h00});
    endfunction

    task automatic wait_xfers(input int target, input int budget, input string name);
        int c = 0;
        while (n_xfer < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, 32'(n_xfer >= target), 32'd1);
        #1;
    endtask

    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer: got pc %0h instr %0h, expected no transfer", instr_pc, instr);
            end else begin
                check("xfer", 32'({instr_pc, instr, is_ldi, imm}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst = 1'b1; br = 1'b0; br_target = 8'h00; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_re_bar", 32'(rom_re_bar),  32'd1);
        check("rst_outs",   32'({instr, imm, instr_pc, is_ldi}), 32'd0);

        // Straight-line stream with one LDI pair.
        ex(8'h00, 8'h01, 1'b0, 8'h00);
        ex(8'h01, 8'h0A, 1'b0, 8'h00);
        ex(8'h02, 8'h13, 1'b0, 8'h00);
        ex(8'h03, 8'h1C, 1'b0, 8'h00);
        ex(8'h04, 8'h04, 1'b0, 8'h00);
        ex(8'h05, 8'hF9, 1'b1, 8'h7F);
        ex_plain(7, 24);
        @(posedge clk); #1;
        rst = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        check("first_cycle_empty", 32'({instr_valid, rom_re_bar}), 32'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("consecutive_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'(k)}));
        end
        wait_xfers(7, 30, "ldi_stream_done");

        // Stall: head must hold and fetch must stop once full.
        instr_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (exp_q.size() == 0)
                check("stall_queue", 32'd0, 32'd1);
            else
                check("stall_hold", 32'({instr_valid, instr_pc, instr}),
                      32'({1'b1, exp_q[0].pc, exp_q[0].ins}));
        end
        check("stall_no_fetch", 32'(rom_re_bar), 32'd1);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        nb = n_xfer;
        wait_xfers(nb + 8, 40, "stall_release");

        // Redirect with three entries buffered and nothing consumed.
        @(posedge clk); #1;
        rst = 1'b1; instr_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        br = 1'b1; br_target = 8'h40;
        ex_plain(8'h40, 8'h53);
        @(negedge clk);
        check("br_no_fetch", 32'(rom_re_bar), 32'd1);
        check("preflush_head", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h00}));
        @(posedge clk); #1;
        br = 1'b0; instr_ready = 1'b1;
        nb = n_xfer;
        @(negedge clk);
        check("postflush_empty", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("postflush_first", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h40}));
        wait_xfers(nb + 5, 30, "redirect_stream");

        // Redirect coincident with a transfer, landing next to the wrap point.
        br = 1'b1; br_target = 8'h7E;
        @(posedge clk); #1;
        br = 1'b0;
        exp_q.delete();
        ex(8'h7E, 8'h7E, 1'b0, 8'h00);
        ex(8'h7F, 8'h7F, 1'b0, 8'h00);
        ex(8'h00, 8'h01, 1'b0, 8'h00);
        ex(8'h01, 8'h0A, 1'b0, 8'h00);
        ex(8'h02, 8'h13, 1'b0, 8'h00);
        ex(8'h03, 8'h1C, 1'b0, 8'h00);
        ex(8'h04, 8'h04, 1'b0, 8'h00);
        ex(8'h05, 8'hF9, 1'b1, 8'h7F);
        ex_plain(7, 12);
        nb = n_xfer;
        wait_xfers(nb + 5, 30, "wrap_stream");

        // Reset with only the LDI opcode byte buffered.
        instr_ready = 1'b0; br = 1'b1; br_target = 8'h05;
        exp_q.delete();
        @(posedge clk); #1;
        br = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ldi_half_not_valid", 32'({instr_valid, is_ldi, instr}), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_no_fetch", 32'(rom_re_bar), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; instr_ready = 1'b1;
        ex(8'h00, 8'h01, 1'b0, 8'h00);
        ex(8'h01, 8'h0A, 1'b0, 8'h00);
        ex(8'h02, 8'h13, 1'b0, 8'h00);
        ex(8'h03, 8'h1C, 1'b0, 8'h00);
        nb = n_xfer;
        @(negedge clk);
        check("post_rst_empty", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("post_rst_first", 32'({instr_valid, instr_pc, instr}), 32'({1'b1, 8'h00, 8'h01}));
        wait_xfers(nb + 4, 20, "post_rst_stream");
        instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
